fetch_cycle: RTL and testbench



---
 rtl/fetch_pkg.sv | 31 +++
 rtl/fetch_cycle_if_id_reg.sv | 44 ++++
 rtl/fetch_cycle.sv | 142 ++++++++++++++
 tb/tb_fetch_cycle.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fetch_pkg;

  localparam int INSTR_W = 38;
  localparam int PC_W    = 24;
  localparam int PC_STEP = 4;

  localparam logic [PC_W-1:0]    RESET_PC  = 24'h000000;
  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  // One IF/ID payload: instruction, its PC and the sequential successor.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc_plus4;
  } ifid_t;

  // Sequential successor; wraps naturally modulo 2^PC_W.
  function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
    return pc + PC_W'(PC_STEP);
  endfunction

endpackage

// File: rtl/fetch_cycle_if_id_reg.sv
// IF/ID pipeline register with flush > stall > load > bubble priority.
// Latency: one cycle from load to outputs.
// Backpressure: stall holds contents; flush overrides stall and any load.
module if_id_reg
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               stall,
  input  logic               flush,
  input  ifid_t              load_dat,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc,
  output logic [PC_W-1:0]    pc_plus4,
  output logic               valid
);

  // Register update in priority order; a plain bubble keeps PC fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr    <= NOP_INSTR;
      pc       <= '0;
      pc_plus4 <= '0;
      valid    <= 1'b0;
    end else if (flush) begin
      instr    <= NOP_INSTR;
      pc       <= '0;
      pc_plus4 <= '0;
      valid    <= 1'b0;
    end else if (stall) begin
      valid    <= valid;
    end else if (load) begin
      instr    <= load_dat.instr;
      pc       <= load_dat.pc;
      pc_plus4 <= load_dat.pc_plus4;
      valid    <= 1'b1;
    end else begin
      instr    <= NOP_INSTR;
      valid    <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_cycle.sv
// Instruction fetch: PC, imem req/ready handshake, hold buffer, IF/ID register.
// Latency: word accepted at edge N appears on InstrD after edge N; 1 instr/cycle at zero wait.
// Backpressure: StallF blocks new requests, StallD parks a completed word in a hold buffer.
// Optional build macro FETCH_PERF_EN adds saturating fetch_cnt / wait_cnt outputs.
module fetch_cycle
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               PCSrcE,
  input  logic [PC_W-1:0]    PCTargetE,
  input  logic               StallF,
  input  logic               StallD,
  input  logic               FlushD,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ready,
  output logic [INSTR_W-1:0] InstrD,
  output logic [PC_W-1:0]    PCD,
  output logic [PC_W-1:0]    PCPlus4D,
`ifdef FETCH_PERF_EN
  output logic [31:0]        fetch_cnt,
  output logic [31:0]        wait_cnt,
`endif
  output logic               ValidD
);

  fetch_state_t    state, state_nxt;
  logic [PC_W-1:0] pc, pc_nxt, pc_inc;
  logic            pend, pend_nxt;
  logic [PC_W-1:0] pend_tgt, pend_tgt_nxt;
  ifid_t           hbuf, hbuf_nxt;
  ifid_t           ifid_dat;
  logic            ifid_load;

  assign pc_inc    = pc_next(pc);
  assign imem_req  = (state == REQ);
  assign imem_addr = pc;

  // State, PC, pending redirect and hold buffer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      pend     <= 1'b0;
      pend_tgt <= '0;
      hbuf     <= '0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      pend     <= pend_nxt;
      pend_tgt <= pend_tgt_nxt;
      hbuf     <= hbuf_nxt;
    end
  end

  // Next-state logic; PC stays put while a request is outstanding so the address is stable.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    pend_nxt     = pend;
    pend_tgt_nxt = pend_tgt;
    hbuf_nxt     = hbuf;
    ifid_load    = 1'b0;
    ifid_dat     = {imem_rdata, pc, pc_inc};
    case (state)
      IDLE: begin
        if (PCSrcE) begin
          pc_nxt = PCTargetE;
        end else if (!StallF) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (!imem_ready) begin
          // Remember a redirect seen mid-wait; the latest target wins.
          if (PCSrcE) begin
            pend_nxt     = 1'b1;
            pend_tgt_nxt = PCTargetE;
          end
        end else if (PCSrcE || pend) begin
          // Wrong-path word: drop it and refetch from the target.
          pc_nxt   = PCSrcE ? PCTargetE : pend_tgt;
          pend_nxt = 1'b0;
        end else if (FlushD) begin
          // Decode is being flushed, so the completing word is discarded.
          pc_nxt    = pc_inc;
          state_nxt = StallF ? IDLE : REQ;
        end else if (StallD) begin
          hbuf_nxt  = {imem_rdata, pc, pc_inc};
          pc_nxt    = pc_inc;
          state_nxt = HOLD;
        end else begin
          ifid_load = 1'b1;
          pc_nxt    = pc_inc;
          state_nxt = StallF ? IDLE : REQ;
        end
      end
      HOLD: begin
        ifid_dat = hbuf;
        if (PCSrcE || FlushD) begin
          if (PCSrcE) pc_nxt = PCTargetE;
          state_nxt = REQ;
        end else if (!StallD) begin
          ifid_load = 1'b1;
          state_nxt = StallF ? IDLE : REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (ifid_load),
    .stall    (StallD),
    .flush    (FlushD),
    .load_dat (ifid_dat),
    .instr    (InstrD),
    .pc       (PCD),
    .pc_plus4 (PCPlus4D),
    .valid    (ValidD)
  );

`ifdef FETCH_PERF_EN
  // Saturating counters: effective IF/ID loads and memory wait cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      if (ifid_load && !FlushD && !StallD && (fetch_cnt != 32'hFFFFFFFF))
        fetch_cnt <= fetch_cnt + 32'd1;
      if ((state == REQ) && !imem_ready && (wait_cnt != 32'hFFFFFFFF))
        wait_cnt <= wait_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_cycle.sv
// Bench for fetch_cycle: directed vector table, wrap/reset sequence, random run vs reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_fetch_cycle;
  import fetch_pkg::*;

  logic               clk = 1'b0;
  logic               rst, PCSrcE, StallF, StallD, FlushD, imem_ready;
  logic [PC_W-1:0]    PCTargetE;
  logic [INSTR_W-1:0] imem_rdata;
  logic               imem_req, ValidD;
  logic [PC_W-1:0]    imem_addr, PCD, PCPlus4D;
  logic [INSTR_W-1:0] InstrD;
`ifdef FETCH_PERF_EN
  logic [31:0]        fetch_cnt, wait_cnt;
`endif

  always #5 clk = ~clk;

  fetch_cycle dut (
    .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
`ifdef FETCH_PERF_EN
    .fetch_cnt(fetch_cnt), .wait_cnt(wait_cnt),
`endif
    .ValidD(ValidD)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: sequential fetch with an outstanding-request flag,
  // a queue holding at most one parked word and a queue of redirect targets.
  logic [PC_W-1:0] m_pc;
  bit              m_req;
  ifid_t           m_buf[$];
  logic [PC_W-1:0] m_redir[$];
  bit              m_vld;
  ifid_t           m_ifid;
  longint          m_fetch, m_wait;

  function automatic logic [INSTR_W-1:0] tag(input logic [PC_W-1:0] a);
    return {14'h2B3C, a};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic model_update();
    bit    deliver;
    ifid_t item;
    deliver = 0;
    item    = '0;
    if (rst) begin
      m_pc = RESET_PC; m_req = 0; m_buf.delete(); m_redir.delete();
      m_vld = 0; m_ifid = '0; m_fetch = 0; m_wait = 0;
      return;
    end
    if (m_req && !imem_ready) m_wait++;
    if (m_buf.size() > 0) begin
      if (PCSrcE || FlushD) begin
        m_buf.delete();
        if (PCSrcE) m_pc = PCTargetE;
        m_req = 1;
      end else if (!StallD) begin
        deliver = 1; item = m_buf.pop_front(); m_req = !StallF;
      end
    end else if (!m_req) begin
      if (PCSrcE) m_pc = PCTargetE;
      else if (!StallF) m_req = 1;
    end else if (!imem_ready) begin
      if (PCSrcE) begin m_redir.delete(); m_redir.push_back(PCTargetE); end
    end else if (PCSrcE || m_redir.size() > 0) begin
      m_pc = PCSrcE ? PCTargetE : m_redir[0];
      m_redir.delete();
    end else begin
      item = '{instr: tag(m_pc), pc: m_pc, pc_plus4: m_pc + 24'd4};
      m_pc = m_pc + 24'd4;
      if (FlushD) m_req = !StallF;
      else if (StallD) begin m_buf.push_back(item); m_req = 0; end
      else begin deliver = 1; m_req = !StallF; end
    end
    if (FlushD) begin
      m_vld = 0; m_ifid = '0;
    end else if (StallD) begin
      m_vld = m_vld;
    end else if (deliver) begin
      m_vld = 1; m_ifid = item; m_fetch++;
    end else begin
      m_vld = 0; m_ifid.instr = '0;
    end
  endtask

  task automatic check_model(input string ph);
    chk({ph, ".req"},  64'(imem_req),  64'(m_req));
    chk({ph, ".addr"}, 64'(imem_addr), 64'(m_pc));
    chk({ph, ".vld"},  64'(ValidD),    64'(m_vld));
    if (m_vld) begin
      chk({ph, ".instr"}, 64'(InstrD),   64'(m_ifid.instr));
      chk({ph, ".pcd"},   64'(PCD),      64'(m_ifid.pc));
      chk({ph, ".pcp4"},  64'(PCPlus4D), 64'(m_ifid.pc_plus4));
    end else begin
      chk({ph, ".nop"}, 64'(InstrD), 64'(0));
    end
`ifdef FETCH_PERF_EN
    chk({ph, ".fetch_cnt"}, 64'(fetch_cnt), 64'(m_fetch));
    chk({ph, ".wait_cnt"},  64'(wait_cnt),  64'(m_wait));
`endif
  endtask

  // Drive one cycle at the falling edge, advance the model at the rising edge,
  // then check outputs at the next falling edge.
  task automatic step(input bit r, input bit sf, input bit sd, input bit fd,
                      input bit ps, input logic [PC_W-1:0] tgt, input bit rdy,
                      input string ph);
    rst = r; StallF = sf; StallD = sd; FlushD = fd; PCSrcE = ps;
    PCTargetE = tgt; imem_ready = rdy; imem_rdata = tag(m_pc);
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_model(ph);
  endtask

  typedef struct {
    bit sf, sd, fd, ps;
    logic [PC_W-1:0] tgt;
    bit rdy;
    bit e_req;
    logic [PC_W-1:0] e_addr;
    bit e_vld;
    logic [PC_W-1:0] e_pcd;
  } vec_t;

  vec_t tbl[23];

  function automatic vec_t mk(bit sf, bit sd, bit fd, bit ps, logic [PC_W-1:0] tgt, bit rdy,
                              bit e_req, logic [PC_W-1:0] e_addr, bit e_vld, logic [PC_W-1:0] e_pcd);
    vec_t v;
    v.sf = sf; v.sd = sd; v.fd = fd; v.ps = ps; v.tgt = tgt; v.rdy = rdy;
    v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld; v.e_pcd = e_pcd;
    return v;
  endfunction

  initial begin
    //             sf sd fd ps tgt        rdy req addr       vld pcd
    tbl[0]  = mk(0, 0, 0, 0, 24'h0,     1,  1, 24'h000,   0, 24'h0);
    tbl[1]  = mk(0, 0, 0, 0, 24'h0,     1,  1, 24'h004,   1, 24'h000);
    tbl[2]  = mk(0, 0, 0, 0, 24'h0,     1,  1, 24'h008,   1, 24'h004);
    tbl[3]  = mk(0, 0, 0, 0, 24'h0,     0,  1, 24'h008,   0, 24'h0);
    tbl[4]  = mk(0, 0, 0, 0, 24'h0,     0,  1, 24'h008,   0, 24'h0);
    tbl[5]  = mk(0, 0, 0, 0, 24'h0,     0,  1, 24'h008,   0, 24'h0);
    tbl[6]  = mk(0, 0, 0, 0, 24'h0,     1,  1, 24'h00C,   1, 24'h008);
    tbl[7]  = mk(0, 0, 0, 0, 24'h0,     0,  1, 24'h00C,   0, 24'h0);
    tbl[8]  = mk(0, 0, 0, 1, 24'h100,   0,  1, 24'h00C,   0, 24'h0);
    tbl[9]  = mk(0, 0, 0, 0, 24'h0,     0,  1, 24'h00C,   0, 24'h0);
    tbl[10] = mk(0, 0, 0, 0, 24'h0,     1,  1, 24'h100,   0, 24'h0);
    tbl[11] = mk(0, 0, 0, 1, 24'h00C,   1,  1, 24'h00C,   0, 24'h0);
    tbl[12] = mk(0, 0, 0, 0, 24'h0,     1,  1, 24'h010,   1, 24'h00C);
    tbl[13] = mk(0, 1, 0, 0, 24'h0,     1,  0, 24'h014,   1, 24'h00C);
    tbl[14] = mk(0, 1, 0, 0, 24'h0,     1,  0, 24'h014,   1, 24'h00C);
    tbl[15] = mk(0, 0, 0, 0, 24'h0,     1,  1, 24'h014,   1, 24'h010);
    tbl[16] = mk(0, 0, 0, 0, 24'h0,     1,  1, 24'h018,   1, 24'h014);
    tbl[17] = mk(0, 0, 1, 0, 24'h0,     1,  1, 24'h01C,   0, 24'h0);
    tbl[18] = mk(0, 0, 0, 0, 24'h0,     1,  1, 24'h020,   1, 24'h01C);
    tbl[19] = mk(1, 1, 0, 0, 24'h0,     1,  0, 24'h024,   1, 24'h01C);
    tbl[20] = mk(1, 0, 0, 0, 24'h0,     1,  0, 24'h024,   1, 24'h020);
    tbl[21] = mk(1, 0, 0, 0, 24'h0,     1,  0, 24'h024,   0, 24'h0);
    tbl[22] = mk(0, 0, 0, 0, 24'h0,     1,  1, 24'h024,   0, 24'h0);

    rst = 1; StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0;
    PCTargetE = '0; imem_ready = 0; imem_rdata = '0;
    m_pc = RESET_PC; m_req = 0; m_vld = 0; m_ifid = '0; m_fetch = 0; m_wait = 0;
    @(negedge clk);
    step(1, 0, 0, 0, 0, 24'h0, 0, "reset0");
    step(1, 0, 0, 0, 0, 24'h0, 1, "reset1");
    chk("reset.instr", 64'(InstrD), 64'(0));
    chk("reset.pcd",   64'(PCD), 64'(0));
    chk("reset.pcp4",  64'(PCPlus4D), 64'(0));

    for (int i = 0; i < 23; i++) begin
      step(0, tbl[i].sf, tbl[i].sd, tbl[i].fd, tbl[i].ps, tbl[i].tgt, tbl[i].rdy,
           $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.req", i),  64'(imem_req),  64'(tbl[i].e_req));
      chk($sformatf("tbl%0d.addr", i), 64'(imem_addr), 64'(tbl[i].e_addr));
      chk($sformatf("tbl%0d.vld", i),  64'(ValidD),    64'(tbl[i].e_vld));
      if (tbl[i].e_vld) begin
        chk($sformatf("tbl%0d.pcd", i),   64'(PCD),      64'(tbl[i].e_pcd));
        chk($sformatf("tbl%0d.pcp4", i),  64'(PCPlus4D), 64'(tbl[i].e_pcd + 24'd4));
        chk($sformatf("tbl%0d.instr", i), 64'(InstrD),   64'({14'h2B3C, tbl[i].e_pcd}));
      end else begin
        chk($sformatf("tbl%0d.nop", i), 64'(InstrD), 64'(0));
      end
`ifdef FETCH_PERF_EN
      if (i == 6) chk("tbl6.wait_cnt", 64'(wait_cnt), 64'(3));
`endif
    end

    // PC wrap at the top of the address space, then reset during a wait.
    step(0, 0, 0, 0, 1, 24'hFFFFF8, 1, "wrap0");
    step(0, 0, 0, 0, 0, 24'h0, 1, "wrap1");
    step(0, 0, 0, 0, 0, 24'h0, 1, "wrap2");
    chk("wrap.pcd",  64'(PCD),       64'(24'hFFFFFC));
    chk("wrap.pcp4", 64'(PCPlus4D),  64'(0));
    chk("wrap.addr", 64'(imem_addr), 64'(0));
    step(0, 0, 0, 0, 0, 24'h0, 1, "wrap3");
    step(0, 0, 0, 0, 0, 24'h0, 0, "wait0");
    chk("wait.addr", 64'(imem_addr), 64'(4));
    step(1, 0, 0, 0, 0, 24'h0, 0, "midrst");
    chk("midrst.req",  64'(imem_req),  64'(0));
    chk("midrst.addr", 64'(imem_addr), 64'(RESET_PC));
    chk("midrst.vld",  64'(ValidD),    64'(0));

    for (int i = 0; i < 3000; i++) begin
      bit sd, fd;
      sd = ($urandom_range(0, 99) < 15);
      fd = !sd && ($urandom_range(0, 99) < 8);
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 99) < 15), sd, fd,
           ($urandom_range(0, 99) < 10),
           PC_W'($urandom) & 24'hFFFFFC,
           ($urandom_range(0, 99) < 70), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
